// File: rtl/serial_parallel_rx.sv
// Serial-to-parallel receiver: collects DATA_WIDTH qualified bits into a word,
// presents it on a one-entry valid/ready holding register and flags aborted
// words (frame_err) and dropped words (overrun) as one-cycle pulses.
module serial_parallel_rx #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serial_in,
    input  logic                  serial_valid,
    output logic [DATA_WIDTH-1:0] parallel_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] sr_next;
    logic                  word_done;

    // Insert one bit into the shift register in the configured bit order.
    function automatic logic [DATA_WIDTH-1:0] shift_in(
        input logic [DATA_WIDTH-1:0] cur,
        input logic                  b
    );
        if (MSB_FIRST)
            return {cur[DATA_WIDTH-2:0], b};
        else
            return {b, cur[DATA_WIDTH-1:1]};
    endfunction

    // The completed word includes the bit sampled on the completing edge,
    // so the holding register loads the post-shift value.
    assign sr_next   = shift_in(sr, serial_in);
    assign word_done = (state == SHIFT) && serial_valid && (cnt == LAST_CNT);

    // Bit-collection FSM: counts qualified bits, aborts on a gap inside a word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (serial_valid) begin
                        sr    <= sr_next;
                        cnt   <= CNT_W'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (serial_valid) begin
                        sr <= sr_next;
                        if (cnt == LAST_CNT) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        // Gap inside a word: drop the partial word entirely.
                        sr        <= '0;
                        cnt       <= '0;
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Holding register: accepts a completed word if empty or drained on the
    // same edge, otherwise keeps the old word and reports the drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parallel_out <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (word_done) begin
                if (!out_valid || out_ready) begin
                    parallel_out <= sr_next;
                    out_valid    <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_parallel_rx.sv
// Directed testbench for serial_parallel_rx: one MSB-first and one LSB-first
// instance, expected words queued as they are sent and popped on delivery.
module tb_serial_parallel_rx;

    logic       clk;
    logic       rst;

    logic       sin1, sv1, rdy1;
    logic [7:0] pout1;
    logic       ov1, ferr1, orun1;

    logic       sin0, sv0, rdy0;
    logic [7:0] pout0;
    logic       ov0, ferr0, orun0;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    serial_parallel_rx #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (sin1),
        .serial_valid (sv1),
        .parallel_out (pout1),
        .out_valid    (ov1),
        .out_ready    (rdy1),
        .frame_err    (ferr1),
        .overrun      (orun1)
    );

    serial_parallel_rx #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (sin0),
        .serial_valid (sv0),
        .parallel_out (pout0),
        .out_valid    (ov0),
        .out_ready    (rdy0),
        .frame_err    (ferr0),
        .overrun      (orun0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed %0h expected none (scoreboard empty)", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {24'd0, obs}, {24'd0, e});
        end
    endtask

    // One edge with the MSB-first instance sampling bit b.
    task automatic bit_msb(input logic b);
        sv1  = 1'b1;
        sin1 = b;
        @(posedge clk);
        #1;
    endtask

    // First n bits of w, MSB first, into the MSB-first instance.
    task automatic send_msb(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) bit_msb(w[7-i]);
    endtask

    // First n bits of w, LSB first, into the LSB-first instance.
    task automatic send_lsb(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            sv0  = 1'b1;
            sin0 = w[i];
            @(posedge clk);
            #1;
        end
    endtask

    // One edge with both instances idle.
    task automatic idle();
        sv1  = 1'b0;
        sin1 = 1'b1;
        sv0  = 1'b0;
        sin0 = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        sin1 = 1'b0; sv1 = 1'b0; rdy1 = 1'b0;
        sin0 = 1'b0; sv0 = 1'b0; rdy0 = 1'b0;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pout",  {24'd0, pout1}, 32'h0);
        chk("rst_valid", {31'd0, ov1},   32'h0);
        chk("rst_ferr",  {31'd0, ferr1}, 32'h0);
        chk("rst_orun",  {31'd0, orun1}, 32'h0);
        rst = 1'b0;
        idle();

        // Asynchronous reset while a word is held
        exp_q.push_back(8'hFF);
        send_msb(8'hFF, 8);
        chk("pre_arst_valid", {31'd0, ov1}, 32'h1);
        chk_word("pre_arst_word", pout1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, ov1},   32'h0);
        chk("arst_pout",  {24'd0, pout1}, 32'h0);
        #1 rst = 1'b0;
        idle();
        idle();
        chk("post_rst_valid", {31'd0, ov1}, 32'h0);

        // Single word A5, consumer ready
        rdy1 = 1'b1;
        exp_q.push_back(8'hA5);
        send_msb(8'hA5, 8);
        chk("a5_valid", {31'd0, ov1},   32'h1);
        chk_word("a5_word", pout1);
        chk("a5_ferr",  {31'd0, ferr1}, 32'h0);
        chk("a5_orun",  {31'd0, orun1}, 32'h0);
        idle();
        chk("a5_consumed", {31'd0, ov1}, 32'h0);

        // Back-to-back 3C, C3 with consumer stalled: C3 is dropped
        rdy1 = 1'b0;
        exp_q.push_back(8'h3C);
        send_msb(8'h3C, 8);
        chk("b2b_valid1", {31'd0, ov1},   32'h1);
        chk("b2b_orun1",  {31'd0, orun1}, 32'h0);
        chk_word("b2b_word1", pout1);
        send_msb(8'hC3, 8);
        chk("b2b_orun2",  {31'd0, orun1}, 32'h1);
        chk("b2b_keep",   {24'd0, pout1}, 32'h3C);
        chk("b2b_valid2", {31'd0, ov1},   32'h1);
        idle();
        chk("b2b_orun_pulse", {31'd0, orun1}, 32'h0);
        chk("b2b_still_valid", {31'd0, ov1}, 32'h1);
        rdy1 = 1'b1;
        idle();
        rdy1 = 1'b0;
        chk("b2b_drained", {31'd0, ov1}, 32'h0);

        // Consume on the completion edge of the next word
        exp_q.push_back(8'h11);
        send_msb(8'h11, 8);
        chk_word("coc_word1", pout1);
        exp_q.push_back(8'h22);
        send_msb(8'h22, 7);
        rdy1 = 1'b1;
        bit_msb(1'b0);
        chk("coc_valid", {31'd0, ov1},   32'h1);
        chk_word("coc_word2", pout1);
        chk("coc_orun",  {31'd0, orun1}, 32'h0);
        idle();
        chk("coc_drained", {31'd0, ov1}, 32'h0);

        // Framing error after 5 bits, then a clean word
        send_msb(8'hFF, 5);
        idle();
        chk("fe_pulse", {31'd0, ferr1}, 32'h1);
        chk("fe_valid", {31'd0, ov1},   32'h0);
        chk("fe_orun",  {31'd0, orun1}, 32'h0);
        idle();
        chk("fe_once", {31'd0, ferr1}, 32'h0);
        exp_q.push_back(8'h81);
        send_msb(8'h81, 8);
        chk("fe_next_valid", {31'd0, ov1}, 32'h1);
        chk_word("fe_next_word", pout1);
        idle();

        // LSB-first instance: 1,0,1,0,0,1,0,1 assembles to A5
        rdy0 = 1'b1;
        exp_q.push_back(8'hA5);
        send_lsb(8'hA5, 8);
        chk("lsb_valid", {31'd0, ov0}, 32'h1);
        chk_word("lsb_a5", pout0);
        idle();

        // Reset in the middle of a word, then 5A must carry no residue
        send_lsb(8'hFF, 4);
        #2 rst = 1'b1;
        #1;
        chk("lsb_arst_pout", {24'd0, pout0}, 32'h0);
        #1 rst = 1'b0;
        idle();
        exp_q.push_back(8'h5A);
        send_lsb(8'h5A, 7);
        chk("lsb_no_early", {31'd0, ov0}, 32'h0);
        send_lsb(8'h00, 0);
        sv0 = 1'b1; sin0 = 1'b0;
        @(posedge clk); #1;
        chk("lsb_5a_valid", {31'd0, ov0}, 32'h1);
        chk_word("lsb_5a", pout0);
        chk("lsb_ferr", {31'd0, ferr0}, 32'h0);
        idle();

        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
